// File: rtl/periph_bus_pkg.sv
// periph_bus shared definitions: address map, TCON bits, write merge.
// Imported by periph_bus and periph_timer.
package periph_bus_pkg;

  localparam logic [31:0] DM_LIMIT_DEF    = 32'h4000_0000;
  localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;

  // Byte offsets 0x00..0x14 expressed as word indices.
  localparam logic [29:0] WOFS_TH      = 30'h0;
  localparam logic [29:0] WOFS_TL      = 30'h1;
  localparam logic [29:0] WOFS_TCON    = 30'h2;
  localparam logic [29:0] WOFS_LED     = 30'h3;
  localparam logic [29:0] WOFS_BCD     = 30'h4;
  localparam logic [29:0] WOFS_SYSTICK = 30'h5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IF = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_BCD,
    SEL_TICK
  } reg_sel_e;

  function automatic reg_sel_e decode_sel(
    input logic [29:0] wofs
  );
    reg_sel_e s;
    unique case (wofs)
      WOFS_TH:      s = SEL_TH;
      WOFS_TL:      s = SEL_TL;
      WOFS_TCON:    s = SEL_TCON;
      WOFS_LED:     s = SEL_LED;
      WOFS_BCD:     s = SEL_BCD;
      WOFS_SYSTICK: s = SEL_TICK;
      default:      s = SEL_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] wr_merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic        word,
    input logic [1:0]  lane
  );
    logic [31:0] r;
    r = old;
    if (word) begin
      r = wdata;
    end else begin
      unique case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/periph_bus_timer.sv
// periph_timer: TH/TL/TCON timer with reload on overflow and irq flag.
// Bus writes arrive pre-decoded; merge of byte lanes happens here.
module periph_timer
  import periph_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic        word,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [2:0]  tcon_w;
  logic        ovf;

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    ovf    = 1'b0;
    tcon_w = (word || lane == 2'd0) ? wdata[2:0] : tcon_q;

    if (wr_th) begin
      th_d = wr_merge(th_q, wdata, word, lane);
    end

    if (wr_tl) begin
      tl_d = wr_merge(tl_q, wdata, word, lane);
    end else if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        ovf  = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (wr_tcon) begin
      tcon_d[TCON_EN] = tcon_w[TCON_EN];
      tcon_d[TCON_IE] = tcon_w[TCON_IE];
      tcon_d[TCON_IF] = tcon_q[TCON_IF] & tcon_w[TCON_IF];
    end

    // Hardware set beats a same-cycle clearing write.
    if (ovf && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IF] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = tcon_q[TCON_IE] & tcon_q[TCON_IF];

endmodule

// File: rtl/periph_bus.sv
// periph_bus: routes bus accesses to data memory or peripheral registers.
// Holds LED, BCD and SYSTICK; timer lives in periph_timer.
module periph_bus
  import periph_bus_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT    = DM_LIMIT_DEF,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF,
  parameter int          N_LED       = 8,
  parameter int          CNT_W       = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             Write_enable,
  input  logic             Read_enable,
  input  logic             WordorByte,
  input  logic [31:0]      Addr,
  input  logic [31:0]      Write_data,
  output logic [31:0]      Read_data,
  output logic             dm_wen,
  output logic             dm_ren,
  input  logic [31:0]      dm_rdata,
  output logic [N_LED-1:0] led,
  output logic [31:0]      bcd,
  output logic             irq
);

  logic             dm_sel;
  logic             per_wr;
  logic [29:0]      wofs;
  reg_sel_e         sel;

  logic [N_LED-1:0] led_q, led_d;
  logic [31:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] tick_q, tick_d;

  logic [31:0]      t_th;
  logic [31:0]      t_tl;
  logic [2:0]       t_tcon;
  logic [31:0]      reg_rdata;

  assign dm_sel = (Addr < DM_LIMIT);
  assign dm_wen = Write_enable & dm_sel;
  assign dm_ren = Read_enable & dm_sel;

  // Word index relative to the window; wraps harmlessly below the base.
  assign wofs   = Addr[31:2] - PERIPH_BASE[31:2];
  assign sel    = dm_sel ? SEL_NONE : decode_sel(wofs);
  assign per_wr = Write_enable & ~dm_sel;

  always_comb begin
    led_d  = led_q;
    bcd_d  = bcd_q;
    tick_d = tick_q + CNT_W'(1);

    if (per_wr && sel == SEL_LED) begin
      led_d = N_LED'(wr_merge(32'(led_q), Write_data,
                              WordorByte, Addr[1:0]));
    end
    if (per_wr && sel == SEL_BCD) begin
      bcd_d = wr_merge(bcd_q, Write_data, WordorByte, Addr[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q  <= '0;
      bcd_q  <= '0;
      tick_q <= '0;
    end else begin
      led_q  <= led_d;
      bcd_q  <= bcd_d;
      tick_q <= tick_d;
    end
  end

  periph_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (per_wr && sel == SEL_TH),
    .wr_tl   (per_wr && sel == SEL_TL),
    .wr_tcon (per_wr && sel == SEL_TCON),
    .word    (WordorByte),
    .lane    (Addr[1:0]),
    .wdata   (Write_data),
    .th      (t_th),
    .tl      (t_tl),
    .tcon    (t_tcon),
    .irq     (irq)
  );

  always_comb begin
    reg_rdata = '0;
    unique case (sel)
      SEL_TH:   reg_rdata = t_th;
      SEL_TL:   reg_rdata = t_tl;
      SEL_TCON: reg_rdata = 32'(t_tcon);
      SEL_LED:  reg_rdata = 32'(led_q);
      SEL_BCD:  reg_rdata = bcd_q;
      SEL_TICK: reg_rdata = 32'(tick_q);
      default:  reg_rdata = '0;
    endcase

    Read_data = '0;
    if (Read_enable) begin
      Read_data = dm_ren ? dm_rdata : reg_rdata;
    end
  end

  assign led = led_q;
  assign bcd = bcd_q;

endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: scenario tasks with a scoreboard of expected values.
// Expectations are queued at stimulus time and drained per scenario.
module tb_periph_bus;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_BCD  = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        Write_enable;
  logic        Read_enable;
  logic        WordorByte;
  logic [31:0] Addr;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        dm_wen;
  logic        dm_ren;
  logic [31:0] dm_rdata;
  logic [7:0]  led;
  logic [31:0] bcd;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] tick;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       nm_q[$];

  periph_bus #(.N_LED(8), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .Write_enable (Write_enable),
    .Read_enable  (Read_enable),
    .WordorByte   (WordorByte),
    .Addr         (Addr),
    .Write_data   (Write_data),
    .Read_data    (Read_data),
    .dm_wen       (dm_wen),
    .dm_ren       (dm_ren),
    .dm_rdata     (dm_rdata),
    .led          (led),
    .bcd          (bcd),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Free-running cycle model of SYSTICK.
  always @(posedge clk) begin
    if (reset) tick <= 32'd0;
    else       tick <= tick + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic w);
    Write_enable = 1'b1;
    WordorByte   = w;
    Addr         = a;
    Write_data   = d;
    cyc();
    Write_enable = 1'b0;
    WordorByte   = 1'b1;
  endtask

  task automatic rd(input string n, input logic [31:0] a,
                    input logic [31:0] e);
    nm_q.push_back(n);
    exp_q.push_back(e);
    Read_enable = 1'b1;
    Addr        = a;
    #1;
    obs_q.push_back(Read_data);
    Read_enable = 1'b0;
  endtask

  task automatic sig(input string n, input logic [31:0] o,
                     input logic [31:0] e);
    nm_q.push_back(n);
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    logic [31:0] e, o;
    string n;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    rd("rst_th", A_TH, 32'h0);
    rd("rst_tl", A_TL, 32'h0);
    rd("rst_tcon", A_TCON, 32'h0);
    rd("rst_led_reg", A_LED, 32'h0);
    rd("rst_bcd_reg", A_BCD, 32'h0);
    rd("rst_tick", A_TICK, 32'h0);
    sig("rst_irq", 32'(irq), 32'h0);
    sig("rst_led", 32'(led), 32'h0);
    sig("rst_bcd", bcd, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_word_bcd();
    logic [31:0] e, o;
    string n;
    wr(A_BCD, 32'h0000_1234, 1'b1);
    sig("bcd_out", bcd, 32'h0000_1234);
    rd("bcd_word", A_BCD, 32'h0000_1234);
    wr(A_BCD + 32'd2, 32'hFFFF_FF77, 1'b0);
    rd("bcd_lane2", A_BCD, 32'h0077_1234);
    wr(A_TH, 32'hCAFE_F00D, 1'b1);
    rd("th_word", A_TH, 32'hCAFE_F00D);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_byte_led();
    logic [31:0] e, o;
    string n;
    wr(A_LED + 32'd1, 32'h0000_00AB, 1'b0);
    rd("led_lane1", A_LED, 32'h0);
    sig("led_out_lane1", 32'(led), 32'h0);
    wr(A_LED, 32'h0000_005A, 1'b0);
    sig("led_out_lane0", 32'(led), 32'h5A);
    rd("led_lane0", A_LED, 32'h5A);
    wr(A_LED, 32'h0000_0123, 1'b1);
    rd("led_word_trunc", A_LED, 32'h23);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] e, o;
    string n;
    Write_enable = 1'b1;
    Read_enable  = 1'b1;
    WordorByte   = 1'b1;
    Addr         = A_BCD;
    Write_data   = 32'hA5A5_A5A5;
    nm_q.push_back("rw_old");
    exp_q.push_back(32'h0077_1234);
    #1;
    obs_q.push_back(Read_data);
    cyc();
    Write_enable = 1'b0;
    Read_enable  = 1'b0;
    rd("rw_new", A_BCD, 32'hA5A5_A5A5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] e, o;
    string n;
    dm_rdata    = 32'hDEAD_BEEF;
    Read_enable = 1'b1;
    Addr        = 32'h3FFF_FFFC;
    #1;
    sig("dm_read", Read_data, 32'hDEAD_BEEF);
    sig("dm_ren_hi", 32'(dm_ren), 32'h1);
    Addr = A_TICK;
    #1;
    sig("tick_read", Read_data, tick);
    sig("dm_ren_lo", 32'(dm_ren), 32'h0);
    Read_enable = 1'b0;
    wr(32'h4000_0020, 32'hFFFF_FFFF, 1'b1);
    rd("undef_rd", 32'h4000_0020, 32'h0);
    rd("undef_th", A_TH, 32'hCAFE_F00D);
    rd("undef_tl", A_TL, 32'h0);
    rd("undef_tcon", A_TCON, 32'h0);
    rd("undef_led", A_LED, 32'h23);
    rd("undef_bcd", A_BCD, 32'hA5A5_A5A5);
    Write_enable = 1'b1;
    WordorByte   = 1'b1;
    Addr         = 32'h0000_000C;
    Write_data   = 32'h0000_00FF;
    #1;
    sig("dm_wen_hi", 32'(dm_wen), 32'h1);
    cyc();
    Write_enable = 1'b0;
    rd("dm_wr_led", A_LED, 32'h23);
    wr(32'h8000_0010, 32'h1111_1111, 1'b1);
    rd("high_rd", 32'h8000_0010, 32'h0);
    rd("high_bcd", A_BCD, 32'hA5A5_A5A5);
    Read_enable = 1'b0;
    Addr        = A_BCD;
    #1;
    sig("rd_en_lo", Read_data, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] e, o;
    string n;
    wr(A_TH, 32'hFFFF_FFFD, 1'b1);
    wr(A_TL, 32'hFFFF_FFFE, 1'b1);
    wr(A_TCON, 32'h3, 1'b1);
    rd("t0_tl", A_TL, 32'hFFFF_FFFE);
    sig("t0_irq", 32'(irq), 32'h0);
    cyc();
    rd("t1_tl", A_TL, 32'hFFFF_FFFF);
    sig("t1_irq", 32'(irq), 32'h0);
    cyc();
    rd("t2_tl_reload", A_TL, 32'hFFFF_FFFD);
    sig("t2_irq", 32'(irq), 32'h1);
    rd("t2_tcon", A_TCON, 32'h7);
    wr(A_TCON, 32'h3, 1'b1);
    sig("t3_irq_clr", 32'(irq), 32'h0);
    rd("t3_tl", A_TL, 32'hFFFF_FFFE);
    rd("t3_tcon", A_TCON, 32'h3);
    cyc();
    rd("t4_tl", A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3, 1'b1);
    sig("t5_set_wins", 32'(irq), 32'h1);
    rd("t5_tl", A_TL, 32'hFFFF_FFFD);
    rd("t5_tcon", A_TCON, 32'h7);
    wr(A_TL, 32'h0000_0010, 1'b1);
    rd("t6_tl_wr", A_TL, 32'h10);
    cyc();
    rd("t7_tl", A_TL, 32'h11);
    wr(A_TCON, 32'h0, 1'b1);
    rd("t8_tl", A_TL, 32'h12);
    sig("t8_irq", 32'(irq), 32'h0);
    cyc();
    rd("t9_tl_hold", A_TL, 32'h12);
    wr(A_TL, 32'hFFFF_FFFF, 1'b1);
    wr(A_TCON, 32'h1, 1'b1);
    cyc();
    rd("noie_tl", A_TL, 32'hFFFF_FFFD);
    rd("noie_tcon", A_TCON, 32'h1);
    sig("noie_irq", 32'(irq), 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  task automatic test_reset_run();
    logic [31:0] e, o;
    string n;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wr(A_TH, 32'h0, 1'b1);
    wr(A_TL, 32'hFFFF_FFFF, 1'b1);
    wr(A_TCON, 32'h3, 1'b1);
    cyc();
    wr(A_LED, 32'h5A, 1'b1);
    wr(A_BCD, 32'h99, 1'b1);
    for (int i = 0; i < 200 && tick != 32'd100; i++) cyc();
    rd("pre_tick", A_TICK, 32'd100);
    sig("pre_irq", 32'(irq), 32'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd("rr_th", A_TH, 32'h0);
    rd("rr_tl", A_TL, 32'h0);
    rd("rr_tcon", A_TCON, 32'h0);
    rd("rr_led", A_LED, 32'h0);
    rd("rr_bcd", A_BCD, 32'h0);
    rd("rr_tick0", A_TICK, 32'h0);
    sig("rr_irq", 32'(irq), 32'h0);
    sig("rr_led_out", 32'(led), 32'h0);
    cyc();
    rd("rr_tick1", A_TICK, 32'h1);
    rd("rr_tl_idle", A_TL, 32'h0);
    cyc();
    rd("rr_tick2", A_TICK, 32'h2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h want %h", n, o, e);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    Write_enable = 1'b0;
    Read_enable  = 1'b0;
    WordorByte   = 1'b1;
    Addr         = 32'h0;
    Write_data   = 32'h0;
    dm_rdata     = 32'h0;
    test_reset();
    test_word_bcd();
    test_byte_led();
    test_rw_same();
    test_decode();
    test_timer();
    test_reset_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_bus.md
PERIPH_BUS -- requirements
Module: periph_bus

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  - DM_LIMIT, 32'h40000000, addresses below this route to data memory.
  - PERIPH_BASE, 32'h40000000, base of the peripheral register window.
  - N_LED, 8, LED register width (1..32).
  - CNT_W, 32, SysTick counter width (1..32).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  - clk  in  1  single clock; all state updates on the rising edge.
  - reset  in  1  synchronous, active-high.
  - Write_enable  in  1  bus write strobe.
  - Read_enable  in  1  bus read strobe.
  - WordorByte  in  1  1 = word access, 0 = byte access.
  - Addr  in  32  byte address.
  - Write_data  in  32  write data; byte writes use [7:0].
  - Read_data  out  32  read data.
  - dm_wen  out  1  data-memory write enable.
  - dm_ren  out  1  data-memory read enable.
  - dm_rdata  in  32  data-memory read data.
  - led  out  N_LED  LED register contents.
  - bcd  out  32  BCD register contents.
  - irq  out  1  timer interrupt.
REQ-003 One clock domain SHALL be used (clk); reset SHALL be synchronous and active-high (reset).

Function
REQ-004 dm_wen SHALL equal Write_enable && (Addr < DM_LIMIT), and dm_ren SHALL equal Read_enable && (Addr < DM_LIMIT); both are combinational.
REQ-005 Peripheral registers SHALL be selected by Addr[31:2] relative to PERIPH_BASE, with word offsets:
  - 0x00 TH: timer reload, RW.
  - 0x04 TL: timer count, RW.
  - 0x08 TCON: [0] enable, [1] irq_en, [2] irq_flag; other bits read 0.
  - 0x0C LED: RW, bits [N_LED-1:0].
  - 0x10 BCD: RW, 32-bit.
  - 0x14 SYSTICK: RO.
REQ-006 Accesses in the peripheral window to undefined offsets SHALL read 0 and ignore writes.
REQ-007 Addresses at or above DM_LIMIT and outside the peripheral window SHALL read 0 and ignore writes.
REQ-008 Read_data SHALL be combinational, with zero added latency, in this priority:
  - 0 when Read_enable = 0;
  - else dm_rdata when dm_ren = 1;
  - else the addressed register, zero-extended.
  Reads return the value held before the current edge.
REQ-009 Word writes SHALL replace the addressed register at the clock edge.
REQ-010 Byte writes SHALL replace only byte lane Addr[1:0] with Write_data[7:0]; the other lanes are unchanged.
REQ-011 All register writes SHALL be edge-registered; no level-sensitive storage is permitted.
REQ-012 SYSTICK SHALL increment by 1 every cycle, wrap from 2^CNT_W-1 to 0, and ignore writes.
REQ-013 When TCON[0]=1 and no bus write targets TL, TL SHALL behave as follows:
  - if TL != 32'hFFFFFFFF, TL increments by 1;
  - if TL == 32'hFFFFFFFF, the next TL is TH, and TCON[2] is set if TCON[1]=1.
REQ-014 When TCON[0]=0, TL SHALL hold its value.
REQ-015 A bus write to TL SHALL take precedence over the increment or reload in the same cycle.
REQ-016 TCON[2] SHALL be set only by hardware and cleared only by a bus write with bit 2 = 0.
REQ-017 If a hardware set and a clearing write to TCON[2] occur in the same cycle, the set SHALL win; bits [1:0] still take the written value.
REQ-018 irq SHALL equal TCON[1] & TCON[2], registered-state derived with no combinational path from bus inputs.
REQ-019 Simultaneous Write_enable and Read_enable to the same register SHALL return the old value and commit the new value at the edge.

Reset
REQ-020 On reset=1 at a clock edge, TH, TL, TCON, LED, BCD and SYSTICK SHALL all become 0; consequently led=0, bcd=0 and irq=0 the following cycle.
REQ-021 Reset SHALL override a timer reload, a bus write or an increment in the same cycle.
REQ-022 Reset asserted mid-count SHALL leave the timer disabled with TL=0.

Structure
REQ-023 A shared package SHALL hold:
  - the register offset constants;
  - the TCON bit indices (TCON_EN=0, TCON_IE=1, TCON_IF=2);
  - the default values of DM_LIMIT and PERIPH_BASE.
REQ-024 The timer (TH/TL/TCON, reload and irq logic) SHALL be one sub-module, periph_timer.
REQ-025 The decode logic, LED, BCD, SYSTICK and read multiplexing SHALL stay in periph_bus.

Verification
REQ-026 Word write 0x00001234 to 0x40000010, then read 0x40000010 -> Read_data=0x00001234 and bcd=0x00001234 from the cycle after the write.
REQ-027 Byte write 0xAB to 0x4000000D with LED=0 -> LED reads 0x0000AB00 masked to N_LED bits (0x00 for N_LED=8); then a byte write 0x5A to 0x4000000C -> led=0x5A.
REQ-028 Timer overflow: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> the sequence is:
  - next cycle TL=0xFFFFFFFF;
  - next cycle TL=0xFFFFFFFD and irq=1;
  - a write of TCON=3 in the same cycle as an overflow leaves irq=1; a write of TCON=3 with no overflow clears irq the next cycle.
REQ-029 Decode check:
  - a read of 0x3FFFFFFC with dm_rdata=0xDEADBEEF -> Read_data=0xDEADBEEF and dm_ren=1;
  - a read of 0x40000014 -> the SYSTICK value with dm_ren=0;
  - a write to 0x40000020 -> no register changes;
  - Read_enable=0 -> Read_data=0.
REQ-030 Assert reset while the timer runs with irq=1 and SYSTICK=100 -> next cycle all registers read 0, irq=0, and SYSTICK restarts counting 0, 1, 2.
